// File: rtl/data_bus_arbiter_if.sv
// Request/grant bundle between the shared-bus endpoints and data_bus_arbiter.
// The master modport is the arbiter side; slave is the endpoint/receiver side.
interface data_bus_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0] req;
   logic               ack;
   logic [NUM_REQ-1:0] grant;
   logic               grant_valid;
   logic [ID_W-1:0]    grant_id;
   logic               busy;
   logic               timeout_err;

   modport master (
      input  req,
      input  ack,
      output grant,
      output grant_valid,
      output grant_id,
      output busy,
      output timeout_err
   );

   modport slave (
      output req,
      output ack,
      input  grant,
      input  grant_valid,
      input  grant_id,
      input  busy,
      input  timeout_err
   );
endinterface

// File: rtl/data_bus_arbiter.sv
// Round-robin owner arbiter for the shared tri-state data bus, one turnaround cycle between grants.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN (limit set by TIMEOUT).
module data_bus_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   data_bus_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_GRANT   = 2'b01,
      ST_RELEASE = 2'b10
   } state_t;

   if ((2 ** ID_W) < NUM_REQ) begin : g_bad_id_w
      $error("data_bus_arbiter: ID_W too narrow for NUM_REQ");
   end
   if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
      $error("data_bus_arbiter: TIMEOUT must be 1..255");
   end

   state_t             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               grant_valid_q, grant_valid_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic               busy_q, busy_d;
   logic               timeout_err_q, timeout_err_d;
   logic               win_found_s;
   logic [ID_W-1:0]    win_idx_s;
   logic [ID_W-1:0]    rr_next_s;
   logic               release_s;
`ifdef ARB_TIMEOUT_EN
   logic [7:0]         hold_cnt_q, hold_cnt_d;
`endif

   // Winner search: first set request at or above rr_ptr, wrapping.
   always_comb begin
      logic [ID_W-1:0] idx_v;
      win_found_s = 1'b0;
      win_idx_s   = '0;
      idx_v       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_v = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!win_found_s && bus.req[idx_v]) begin
            win_found_s = 1'b1;
            win_idx_s   = idx_v;
         end else begin
            win_found_s = win_found_s;
         end
      end
      rr_next_s = (int'(win_idx_s) == (NUM_REQ - 1)) ? '0 : (win_idx_s + ID_W'(1));
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      grant_id_d    = grant_id_q;
      busy_d        = busy_q;
      timeout_err_d = 1'b0;
      release_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_found_s) begin
               state_d             = ST_GRANT;
               grant_d             = '0;
               grant_d[win_idx_s]  = 1'b1;
               grant_valid_d       = 1'b1;
               grant_id_d          = win_idx_s;
               busy_d              = 1'b1;
               rr_ptr_d            = rr_next_s;
            end else begin
               grant_d       = '0;
               grant_valid_d = 1'b0;
               grant_id_d    = '0;
               busy_d        = 1'b0;
            end
         end
         ST_GRANT: begin
            // ack wins over abort and watchdog on the same edge.
            if (bus.ack) begin
               release_s = 1'b1;
            end else if (!bus.req[grant_id_q]) begin
               release_s = 1'b1;
`ifdef ARB_TIMEOUT_EN
            end else if (hold_cnt_q >= 8'(TIMEOUT - 1)) begin
               release_s     = 1'b1;
               timeout_err_d = 1'b1;
`endif
            end else begin
               release_s = 1'b0;
            end
            if (release_s) begin
               state_d       = ST_RELEASE;
               grant_d       = '0;
               grant_valid_d = 1'b0;
               grant_id_d    = '0;
               busy_d        = 1'b1;
            end else begin
               state_d = ST_GRANT;
            end
         end
         ST_RELEASE: begin
            state_d       = ST_IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            grant_id_d    = '0;
            busy_d        = 1'b0;
         end
         default: begin
            state_d       = ST_IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            grant_id_d    = '0;
            busy_d        = 1'b0;
         end
      endcase
   end

`ifdef ARB_TIMEOUT_EN
   // Hold counter: counts completed GRANT cycles, saturating, zero elsewhere.
   always_comb begin
      if ((state_q == ST_GRANT) && (state_d == ST_GRANT)) begin
         hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : (hold_cnt_q + 8'd1);
      end else begin
         hold_cnt_d = 8'd0;
      end
   end

   // Hold counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_q <= 8'd0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end
`endif

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = timeout_err_q;

endmodule
